// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: glyph code width, named glyph codes
// and the all-segments-off pattern.
package seg_pkg;

  localparam int unsigned GLYPH_W = 5;
  localparam int unsigned SEG_W   = 7;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [SEG_W-1:0]   seg_t;

  // Segments are active-low, ordered {a,b,c,d,e,f,g}.
  localparam seg_t SEG_OFF = 7'h7F;

  localparam glyph_t GLYPH_A     = 5'd10;
  localparam glyph_t GLYPH_B     = 5'd11;
  localparam glyph_t GLYPH_C     = 5'd12;
  localparam glyph_t GLYPH_D     = 5'd13;
  localparam glyph_t GLYPH_E     = 5'd14;
  localparam glyph_t GLYPH_F     = 5'd15;
  localparam glyph_t GLYPH_L     = 5'd16;
  localparam glyph_t GLYPH_DASH  = 5'd17;
  localparam glyph_t GLYPH_BLANK = 5'd18;
  localparam glyph_t GLYPH_P     = 5'd19;
  localparam glyph_t GLYPH_N     = 5'd20;
  localparam glyph_t GLYPH_H     = 5'd21;
  localparam glyph_t GLYPH_U     = 5'd22;
  localparam glyph_t GLYPH_T     = 5'd23;

  // Width of a counter over 0..modulus-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/glyph_decoder.sv
// Combinational glyph code to active-low segment pattern; unused codes render blank.
module glyph_decoder
  import seg_pkg::*;
(
  input  logic [GLYPH_W-1:0] code,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      5'd0:        seg = 7'b0000001;
      5'd1:        seg = 7'b1001111;
      5'd2:        seg = 7'b0010010;
      5'd3:        seg = 7'b0000110;
      5'd4:        seg = 7'b1001100;
      5'd5:        seg = 7'b0100100;
      5'd6:        seg = 7'b0100000;
      5'd7:        seg = 7'b0001111;
      5'd8:        seg = 7'b0000000;
      5'd9:        seg = 7'b0000100;
      GLYPH_A:     seg = 7'b0001000;
      GLYPH_B:     seg = 7'b1100000;
      GLYPH_C:     seg = 7'b0110001;
      GLYPH_D:     seg = 7'b1000010;
      GLYPH_E:     seg = 7'b0110000;
      GLYPH_F:     seg = 7'b0111000;
      GLYPH_L:     seg = 7'b1110001;
      GLYPH_DASH:  seg = 7'b1111110;
      GLYPH_BLANK: seg = SEG_OFF;
      GLYPH_P:     seg = 7'b0011000;
      GLYPH_N:     seg = 7'b1101010;
      GLYPH_H:     seg = 7'b1001000;
      GLYPH_U:     seg = 7'b1000001;
      GLYPH_T:     seg = 7'b0111001;
      default:     seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered frame,
// per-digit blanking, blinking and decimal points.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GLYPH_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [NUM_DIGITS-1:0]         anode_out,
  output logic [SEG_W-1:0]              seven_out,
  output logic                          dp_out,
  output logic                          frame_done
);

  localparam int unsigned SLOT_W  = cnt_width(REFRESH_DIV);
  localparam int unsigned BLINK_W = cnt_width(BLINK_DIV);
  localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);
  localparam int unsigned CODE_W  = GLYPH_W * NUM_DIGITS;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic                  slot_wrap, blink_wrap, frame_start;

  logic [CODE_W-1:0]     pend_code_q, pend_code_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [CODE_W-1:0]     act_code_q, act_code_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]      seven_q, seven_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q;

  logic [GLYPH_W-1:0]    code_sel;
  logic [SEG_W-1:0]      dec_seg;
  logic                  dark;

  // Scan and blink timing.
  always_comb begin
    slot_wrap   = (slot_q == SLOT_LAST);
    slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d       = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_start = slot_wrap && (idx_q == IDX_LAST);

    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = phase_q ^ blink_wrap;
  end

  // Double buffer: loads land in pending; active only changes on a frame start, and a
  // load coinciding with the frame start bypasses pending so it shows immediately.
  always_comb begin
    pend_code_d  = pend_code_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_code_d   = act_code_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    act_dp_d     = act_dp_q;

    if (load) begin
      pend_code_d  = digits_in;
      pend_blank_d = blank_mask;
      pend_blink_d = blink_mask;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    if (frame_start) begin
      pend_valid_d = 1'b0;
      if (load) begin
        act_code_d  = digits_in;
        act_blank_d = blank_mask;
        act_blink_d = blink_mask;
        act_dp_d    = dp_in;
      end else if (pend_valid_q) begin
        act_code_d  = pend_code_q;
        act_blank_d = pend_blank_q;
        act_blink_d = pend_blink_q;
        act_dp_d    = pend_dp_q;
      end
    end
  end

  // Outputs are computed from next-state values so they line up with the index change.
  assign code_sel = act_code_d[GLYPH_W*int'(idx_d) +: GLYPH_W];

  glyph_decoder u_glyph_decoder (
    .code(code_sel),
    .seg (dec_seg)
  );

  always_comb begin
    dark           = act_blank_d[idx_d] | (act_blink_d[idx_d] & phase_d);
    anode_d        = '1;
    anode_d[idx_d] = 1'b0;
    seven_d        = dark ? SEG_OFF : dec_seg;
    dp_d           = dark ? 1'b1 : ~act_dp_d[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pend_code_q  <= '0;
      pend_blank_q <= '1;
      pend_blink_q <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_code_q   <= '0;
      act_blank_q  <= '1;
      act_blink_q  <= '0;
      act_dp_q     <= '0;
      anode_q      <= '1;
      seven_q      <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pend_code_q  <= pend_code_d;
      pend_blank_q <= pend_blank_d;
      pend_blink_q <= pend_blink_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_code_q   <= act_code_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      act_dp_q     <= act_dp_d;
      anode_q      <= anode_d;
      seven_q      <= seven_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_start;
    end
  end

  assign anode_out  = anode_q;
  assign seven_out  = seven_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule
